// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolve end of the branch predictor. Each fetched branch pushes its
//   prediction metadata into an in-order queue. When execute resolves the
//   oldest branch, the actual outcome is compared with the prediction. On a
//   mispredict the unit:
//     - pulses a one-cycle repair to the BPU,
//     - issues a fetch redirect,
//     - throws away every younger (wrong-path) entry.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush                 pipeline flush (exception/eret), empties the queue
//   enq_*                 push side: enq_vld/enq_rdy handshake plus metadata
//                         (pc, BTB way, predicted taken/target, local history,
//                         local counter table, GHR, global counter)
//   res_*                 resolve side for the oldest entry: res_vld/res_rdy
//                         handshake, actual direction and target
//   fail, fail_*, fill_*  registered one-cycle BPU repair after a mispredict
//   redirect_vld/_pc      registered one-cycle fetch redirect after a mispredict
module branch_resolve_unit #(
  parameter int GLOBAL_WIDTH   = 8,
  parameter int LOCAL_WIDTH    = 4,
  parameter int B_PATTEN_WIDTH = 2,
  parameter int G_PATTEN_WIDTH = 2,
  parameter int BTB_WAY_NUM    = 4,
  parameter int QUEUE_DEPTH    = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        flush,
  input  logic                                        enq_vld,
  output logic                                        enq_rdy,
  input  logic [31:0]                                 enq_pc,
  input  logic [BTB_WAY_NUM-1:0]                      enq_way_vec,
  input  logic                                        enq_pred_taken,
  input  logic [31:0]                                 enq_pred_pc,
  input  logic [LOCAL_WIDTH-1:0]                      enq_pht_history,
  input  logic [B_PATTEN_WIDTH*(2**LOCAL_WIDTH)-1:0]  enq_pht_patten_tab,
  input  logic [GLOBAL_WIDTH-1:0]                     enq_ghr,
  input  logic [G_PATTEN_WIDTH-1:0]                   enq_ghr_patten,
  input  logic                                        res_vld,
  output logic                                        res_rdy,
  input  logic                                        res_taken,
  input  logic [31:0]                                 res_target,
  output logic                                        fail,
  output logic [31:0]                                 fail_branch,
  output logic [BTB_WAY_NUM-1:0]                      fail_way_vec,
  output logic [31:0]                                 fill_target,
  output logic [LOCAL_WIDTH-1:0]                      fill_pht_history,
  output logic [B_PATTEN_WIDTH*(2**LOCAL_WIDTH)-1:0]  fill_pht_patten_tab,
  output logic [GLOBAL_WIDTH-1:0]                     fail_ghr,
  output logic [GLOBAL_WIDTH-1:0]                     fill_ghr,
  output logic [G_PATTEN_WIDTH-1:0]                   fill_ghr_patten,
  output logic                                        redirect_vld,
  output logic [31:0]                                 redirect_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAB_W = B_PATTEN_WIDTH * (2**LOCAL_WIDTH);

  // Queue storage, one array per metadata field
  logic [31:0]               r_pcMem       [QUEUE_DEPTH];
  logic [BTB_WAY_NUM-1:0]    r_wayMem      [QUEUE_DEPTH];
  logic                      r_predTkMem   [QUEUE_DEPTH];
  logic [31:0]               r_predPcMem   [QUEUE_DEPTH];
  logic [LOCAL_WIDTH-1:0]    r_histMem     [QUEUE_DEPTH];
  logic [TAB_W-1:0]          r_tabMem      [QUEUE_DEPTH];
  logic [GLOBAL_WIDTH-1:0]   r_ghrMem      [QUEUE_DEPTH];
  logic [G_PATTEN_WIDTH-1:0] r_ghrPatMem   [QUEUE_DEPTH];

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic                      r_fail;
  logic [31:0]               r_failBranch;
  logic [BTB_WAY_NUM-1:0]    r_failWayVec;
  logic [31:0]               r_fillTarget;
  logic [LOCAL_WIDTH-1:0]    r_fillHist;
  logic [TAB_W-1:0]          r_fillTab;
  logic [GLOBAL_WIDTH-1:0]   r_failGhr;
  logic [GLOBAL_WIDTH-1:0]   r_fillGhr;
  logic [G_PATTEN_WIDTH-1:0] r_fillGhrPat;
  logic [31:0]               r_redirectPc;

  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_mispredict;
  logic [31:0]               w_headPc;
  logic [BTB_WAY_NUM-1:0]    w_headWay;
  logic                      w_headPredTk;
  logic [31:0]               w_headPredPc;
  logic [LOCAL_WIDTH-1:0]    w_headHist;
  logic [TAB_W-1:0]          w_headTab;
  logic [GLOBAL_WIDTH-1:0]   w_headGhr;
  logic [G_PATTEN_WIDTH-1:0] w_headGhrPat;
  logic [B_PATTEN_WIDTH-1:0] w_headCtr;
  logic [B_PATTEN_WIDTH-1:0] w_newCtr;
  logic [TAB_W-1:0]          w_fillTab;
  logic [G_PATTEN_WIDTH-1:0] w_fillGhrPat;
  logic [31:0]               w_redirectPc;

  // enq_rdy depends only on the current count, so a same-cycle pop never
  // opens a slot for a push while the queue is full.
  assign w_full  = (r_count == CNT_W'(QUEUE_DEPTH));
  assign w_empty = (r_count == '0);
  assign enq_rdy = ~w_full;
  assign res_rdy = ~w_empty;
  assign w_push  = enq_vld & enq_rdy;
  assign w_pop   = res_vld & res_rdy;

  // Head entry is read combinationally so the compare happens in the pop cycle
  assign w_headPc     = r_pcMem[r_rdPtr];
  assign w_headWay    = r_wayMem[r_rdPtr];
  assign w_headPredTk = r_predTkMem[r_rdPtr];
  assign w_headPredPc = r_predPcMem[r_rdPtr];
  assign w_headHist   = r_histMem[r_rdPtr];
  assign w_headTab    = r_tabMem[r_rdPtr];
  assign w_headGhr    = r_ghrMem[r_rdPtr];
  assign w_headGhrPat = r_ghrPatMem[r_rdPtr];

  // A taken branch that went to the wrong target counts as a mispredict even
  // though the direction was right.
  assign w_mispredict = w_pop &
                        ((w_headPredTk != res_taken) |
                         (w_headPredTk & res_taken & (w_headPredPc != res_target)));

  // Repair state: step the selected local counter and the global counter
  // toward the actual outcome, clamping at both ends.
  always_comb begin
    w_headCtr = w_headTab[w_headHist*B_PATTEN_WIDTH +: B_PATTEN_WIDTH];
    w_newCtr  = w_headCtr;
    if (res_taken) begin
      if (w_headCtr != {B_PATTEN_WIDTH{1'b1}}) w_newCtr = w_headCtr + 1'b1;
    end else begin
      if (w_headCtr != '0) w_newCtr = w_headCtr - 1'b1;
    end
    w_fillTab = w_headTab;
    w_fillTab[w_headHist*B_PATTEN_WIDTH +: B_PATTEN_WIDTH] = w_newCtr;

    w_fillGhrPat = w_headGhrPat;
    if (res_taken) begin
      if (w_headGhrPat != {G_PATTEN_WIDTH{1'b1}}) w_fillGhrPat = w_headGhrPat + 1'b1;
    end else begin
      if (w_headGhrPat != '0) w_fillGhrPat = w_headGhrPat - 1'b1;
    end

    // Not-taken resumes after the delay slot
    w_redirectPc = res_taken ? res_target : (w_headPc + 32'd8);
  end

  // Queue storage write; stale contents are harmless because the pointers
  // decide what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pcMem[r_wrPtr]     <= enq_pc;
      r_wayMem[r_wrPtr]    <= enq_way_vec;
      r_predTkMem[r_wrPtr] <= enq_pred_taken;
      r_predPcMem[r_wrPtr] <= enq_pred_pc;
      r_histMem[r_wrPtr]   <= enq_pht_history;
      r_tabMem[r_wrPtr]    <= enq_pht_patten_tab;
      r_ghrMem[r_wrPtr]    <= enq_ghr;
      r_ghrPatMem[r_wrPtr] <= enq_ghr_patten;
    end
  end

  // Pointer and occupancy bookkeeping. A mispredict empties the queue and
  // also discards a push that lands in the same cycle (it is wrong-path).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_mispredict) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Repair/redirect registers: loaded for exactly one cycle after a
  // mispredict, zero otherwise.
  always_ff @(posedge clk) begin
    if (reset || flush || !w_mispredict) begin
      r_fail       <= 1'b0;
      r_failBranch <= '0;
      r_failWayVec <= '0;
      r_fillTarget <= '0;
      r_fillHist   <= '0;
      r_fillTab    <= '0;
      r_failGhr    <= '0;
      r_fillGhr    <= '0;
      r_fillGhrPat <= '0;
      r_redirectPc <= '0;
    end else begin
      r_fail       <= 1'b1;
      r_failBranch <= w_headPc;
      r_failWayVec <= w_headWay;
      r_fillTarget <= res_target;
      r_fillHist   <= {w_headHist[LOCAL_WIDTH-2:0], res_taken};
      r_fillTab    <= w_fillTab;
      r_failGhr    <= w_headGhr;
      r_fillGhr    <= {w_headGhr[GLOBAL_WIDTH-2:0], res_taken};
      r_fillGhrPat <= w_fillGhrPat;
      r_redirectPc <= w_redirectPc;
    end
  end

  assign fail                = r_fail;
  assign redirect_vld        = r_fail;
  assign fail_branch         = r_failBranch;
  assign fail_way_vec        = r_failWayVec;
  assign fill_target         = r_fillTarget;
  assign fill_pht_history    = r_fillHist;
  assign fill_pht_patten_tab = r_fillTab;
  assign fail_ghr            = r_failGhr;
  assign fill_ghr            = r_fillGhr;
  assign fill_ghr_patten     = r_fillGhrPat;
  assign redirect_pc         = r_redirectPc;

endmodule
